bids22_ctrl_seq: RTL

Host-side initiator for the bid controller's C-interface. Accepts one high-level request at a time (configure, lock, unlock, run round) over a valid/ready handshake, sequences C_op/C_data/C_start cycle-accurately, and checks the controller's err/ready/roundOver. It returns one response per request: error code, plus maxBid and winner on a round. Sits between the system host/CPU bridge and the bid controller.

---
 rtl/bids22_pkg.sv | 41 ++++
 rtl/bids22_seq_timer.sv | 36 +++
 rtl/bids22_ctrl_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bids22_pkg.sv
// -----------------------------------------------------------------------------
// bids22_pkg
// Shared definitions for the bid-controller host sequencer:
//   bids_op_t     - controller C_op encoding plus the host-only RUN opcode
//   bids_err_t    - controller err codes plus the sequencer timeout code
//   seq_state_t   - sequencer FSM states
// -----------------------------------------------------------------------------
package bids22_pkg;

   typedef enum logic [3:0] {
      NoOperation = 4'h0,
      Unlock      = 4'h1,
      Lock        = 4'h2,
      LoadX       = 4'h3,
      LoadY       = 4'h4,
      LoadZ       = 4'h5,
      SetXYZ      = 4'h6,
      SetTimer    = 4'h7,
      BidCharge   = 4'h8,
      RUN         = 4'hF
   } bids_op_t;

   typedef enum logic [2:0] {
      ERR_NONE             = 3'd0,
      ERR_BADKEY           = 3'd1,
      ERR_ALREADY_UNLOCKED = 3'd2,
      ERR_START_UNLOCKED   = 3'd3,
      ERR_INVALID_OP       = 3'd4,
      ERR_TIMEOUT          = 3'd7
   } bids_err_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_BACKOFF = 3'd2,
      S_ROUND   = 3'd3,
      S_DRAIN   = 3'd4,
      S_RESP    = 3'd5
   } seq_state_t;

endpackage

// File: rtl/bids22_seq_timer.sv
// -----------------------------------------------------------------------------
// bids22_seq_timer
// Loadable down-counter shared by the BACKOFF, ROUND and DRAIN-timeout phases.
// Ports:
//   clk, reset_n  clock / asynchronous active-low reset
//   load          load load_val (takes priority over en)
//   load_val      value to load (W bits)
//   en            decrement by one, saturating at zero
//   done          count is at its last cycle (count <= 1)
// -----------------------------------------------------------------------------
module bids22_seq_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count <= W'(1));

endmodule

// File: rtl/bids22_ctrl_seq.sv
// -----------------------------------------------------------------------------
// bids22_ctrl_seq
// Host-side initiator for the bid controller's C-interface. Takes one request
// at a time (configure / lock / unlock / run round), drives C_op/C_data/C_start
// cycle-accurately and returns one response per request.
// Ports:
//   clk, reset_n                       clock / async active-low reset
//   req_valid/req_ready/req_op/req_data request channel (req_op 4'hF = RUN)
//   rsp_valid/rsp_ready                 response channel
//   rsp_err/rsp_maxbid/rsp_win          response fields
//   C_op/C_data/C_start                 to controller
//   ready/err/roundOver/maxBid/win      from controller
//   stat_rounds/stat_badkey             statistics (zero unless enabled)
// Optional feature: define BIDS_SEQ_STATS_EN to build the statistics counters.
// -----------------------------------------------------------------------------
module bids22_ctrl_seq
   import bids22_pkg::*;
#(
   parameter int unsigned ROUND_TIMEOUT = 64,
   parameter int unsigned LEN_W         = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_err,
   output logic [31:0] rsp_maxbid,
   output logic [2:0]  rsp_win,
   output logic [3:0]  C_op,
   output logic [31:0] C_data,
   output logic        C_start,
   input  logic        ready,
   input  logic [2:0]  err,
   input  logic        roundOver,
   input  logic [31:0] maxBid,
   input  logic [2:0]  win,
   output logic [15:0] stat_rounds,
   output logic [7:0]  stat_badkey
);

   localparam int unsigned TO_W = $clog2(ROUND_TIMEOUT + 1);
   localparam int unsigned TW   = (LEN_W > TO_W) ? LEN_W : TO_W;

   seq_state_t  state;
   logic        locked;
   logic [3:0]  shadow_timer;
   logic [2:0]  round_err;
   logic        accept;
   logic        tmr_load;
   logic        tmr_en;
   logic [TW-1:0] tmr_val;
   logic        tmr_done;
   logic [LEN_W-1:0] run_len;

   assign accept  = (state == S_IDLE) && req_valid && req_ready;
   assign run_len = req_data[LEN_W-1:0];

   // Timer loads happen on the edge that enters the timed phase, so the
   // phase lasts exactly load_val cycles (done is seen on its last cycle).
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         S_IDLE: begin
            if (accept && (req_op == RUN) && locked) begin
               tmr_load = 1'b1;
               tmr_val  = (run_len == '0) ? TW'(1) : TW'(run_len);
            end
         end
         S_ISSUE: begin
            if (err == ERR_BADKEY) begin
               tmr_load = 1'b1;
               tmr_val  = (shadow_timer == 4'd0) ? TW'(1) : TW'(shadow_timer);
            end
         end
         S_ROUND: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(ROUND_TIMEOUT);
            end
         end
         default: ;
      endcase
   end

   assign tmr_en = (state == S_BACKOFF) || (state == S_ROUND) || (state == S_DRAIN);

   bids22_seq_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_err      <= '0;
         rsp_maxbid   <= '0;
         rsp_win      <= '0;
         C_op         <= '0;
         C_data       <= '0;
         C_start      <= 1'b0;
         locked       <= 1'b0;
         shadow_timer <= 4'hF;
         round_err    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  if (req_op == RUN) begin
                     if (!locked) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ERR_START_UNLOCKED;
                        rsp_maxbid <= '0;
                        rsp_win    <= '0;
                     end else begin
                        state     <= S_ROUND;
                        C_start   <= 1'b1;
                        round_err <= '0;
                     end
                  end else begin
                     state  <= S_ISSUE;
                     C_op   <= req_op;
                     C_data <= req_data;
                  end
               end else begin
                  req_ready <= ready;
               end
            end
            // C_op/C_data still hold the issued request during this cycle.
            S_ISSUE: begin
               C_op   <= '0;
               C_data <= '0;
               if (err == ERR_NONE) begin
                  if (C_op == Lock)     locked       <= 1'b1;
                  if (C_op == Unlock)   locked       <= 1'b0;
                  if (C_op == SetTimer) shadow_timer <= C_data[3:0];
               end
               if (err == ERR_BADKEY) begin
                  state <= S_BACKOFF;
               end else begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= err;
                  rsp_maxbid <= '0;
                  rsp_win    <= '0;
               end
            end
            S_BACKOFF: begin
               if (tmr_done) begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= ERR_BADKEY;
                  rsp_maxbid <= '0;
                  rsp_win    <= '0;
               end
            end
            S_ROUND: begin
               if ((err != ERR_NONE) && (round_err == ERR_NONE)) begin
                  round_err <= err;
               end
               if (tmr_done) begin
                  C_start <= 1'b0;
                  state   <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (roundOver) begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= round_err;
                  rsp_maxbid <= maxBid;
                  rsp_win    <= win;
               end else if (tmr_done) begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= ERR_TIMEOUT;
                  rsp_maxbid <= '0;
                  rsp_win    <= '0;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
                  req_ready <= ready;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BIDS_SEQ_STATS_EN
   logic [15:0] rounds_q;
   logic [7:0]  badkey_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rounds_q <= '0;
         badkey_q <= '0;
      end else begin
         if ((state == S_DRAIN) && roundOver && (rounds_q != '1)) begin
            rounds_q <= rounds_q + 1'b1;
         end
         if ((state == S_ISSUE) && (err == ERR_BADKEY) && (badkey_q != '1)) begin
            badkey_q <= badkey_q + 1'b1;
         end
      end
   end

   assign stat_rounds = rounds_q;
   assign stat_badkey = badkey_q;
`else
   assign stat_rounds = '0;
   assign stat_badkey = '0;
`endif

endmodule
